// File: rtl/uart_transmitter_top.sv
// UART transmitter: serialises one byte per accepted request into a start/data/parity/stop frame.
// Bit timing comes from a per-rate tick divider and OVERSAMPLE ticks per bit period.
module uart_transmitter_top #(
  parameter int unsigned DIV0       = 800,
  parameter int unsigned DIV1       = 400,
  parameter int unsigned DIV2       = 200,
  parameter int unsigned DIV3       = 100,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic [5:0] config_reg,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned Max01  = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned Max23  = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned DivMax = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned DivW   = (DivMax > 1) ? $clog2(DivMax) : 1;
  localparam int unsigned TickW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [7:0]      data_q;
  logic            bits8_q, stop2_q;
  logic [1:0]      par_q, bd_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            load;

  logic [DivW-1:0] div_last;
  logic            tick, bit_end;
  logic [7:0]      data_mask;
  logic            par_en, par_bit;
  logic [2:0]      last_idx, next_idx;

  always_comb begin
    unique case (bd_q)
      2'b00:   div_last = DivW'(DIV0 - 1);
      2'b01:   div_last = DivW'(DIV1 - 1);
      2'b10:   div_last = DivW'(DIV2 - 1);
      default: div_last = DivW'(DIV3 - 1);
    endcase
  end

  assign tick      = (div_cnt_q == div_last);
  assign bit_end   = tick && (tick_cnt_q == TickW'(OVERSAMPLE - 1));
  assign data_mask = bits8_q ? data_q : {1'b0, data_q[6:0]};
  // 2'b11 is treated as "no parity", same as 2'b00
  assign par_en    = par_q[1] ^ par_q[0];
  assign par_bit   = par_q[1] ? (^data_mask) : ~(^data_mask);
  assign last_idx  = bits8_q ? 3'd7 : 3'd6;
  assign next_idx  = bit_idx_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_cnt_d  = div_cnt_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;

    if (state_q != IDLE) begin
      if (tick) begin
        div_cnt_d  = '0;
        tick_cnt_d = bit_end ? '0 : tick_cnt_q + TickW'(1);
      end else begin
        div_cnt_d = div_cnt_q + DivW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        div_cnt_d  = '0;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
        if (tx_start) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == last_idx) begin
            state_d = par_en ? PARITY : STOP;
            tx_d    = par_en ? par_bit : 1'b1;
          end else begin
            bit_idx_d = next_idx;
            tx_d      = data_q[next_idx];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // Shadow copies of the request; frozen for the whole frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      bits8_q <= 1'b0;
      stop2_q <= 1'b0;
      par_q   <= '0;
      bd_q    <= '0;
    end else if (load) begin
      data_q  <= data_in;
      bits8_q <= config_reg[5];
      stop2_q <= config_reg[4];
      par_q   <= config_reg[3:2];
      bd_q    <= config_reg[1:0];
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter_top.sv
// Bench for uart_transmitter_top: a default-rate instance for real bit timing and a
// fast-divider instance for randomized frames, both checked against a frame-bit model.
module tb_uart_transmitter_top;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s, start_f;
  logic [7:0] data_in;
  logic [5:0] config_reg;
  logic       tx_s, busy_s, done_s;
  logic       tx_f, busy_f, done_f;
  int         total = 0;
  int         bad = 0;

  typedef bit bitq_t[$];

  always #5 clk = ~clk;

  uart_transmitter_top dut_slow (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (start_s),
    .data_in    (data_in),
    .config_reg (config_reg),
    .tx         (tx_s),
    .tx_busy    (busy_s),
    .tx_done    (done_s)
  );

  uart_transmitter_top #(
    .DIV0       (6),
    .DIV1       (5),
    .DIV2       (3),
    .DIV3       (2),
    .OVERSAMPLE (16)
  ) dut_fast (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (start_f),
    .data_in    (data_in),
    .config_reg (config_reg),
    .tx         (tx_f),
    .tx_busy    (busy_f),
    .tx_done    (done_f)
  );

  function automatic int div_of(bit fast, logic [1:0] bd);
    int r;
    case (bd)
      2'b00:   r = fast ? 6 : 800;
      2'b01:   r = fast ? 5 : 400;
      2'b10:   r = fast ? 3 : 200;
      default: r = fast ? 2 : 100;
    endcase
    return r;
  endfunction

  // Expected line level for each bit period of the frame, in transmit order
  function automatic bitq_t frame_bits(logic [7:0] d, logic [5:0] c);
    bitq_t q;
    int    n;
    bit    ones;
    ones = 1'b0;
    n = c[5] ? 8 : 7;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(d[i]);
      ones ^= d[i];
    end
    if (c[3:2] == 2'b10) q.push_back(ones);
    else if (c[3:2] == 2'b01) q.push_back(!ones);
    q.push_back(1'b1);
    if (c[4]) q.push_back(1'b1);
    return q;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit fast, input logic v);
    if (fast) start_f = v;
    else start_s = v;
  endtask

  // Called at a negedge; returns at the negedge of the tx_done cycle.
  task automatic run_frame(input bit fast, input logic [7:0] d, input logic [5:0] c,
                           input bit disturb, input string tag);
    bitq_t q;
    int    p;
    int    n;
    q = frame_bits(d, c);
    p = 16 * div_of(fast, c[1:0]);
    n = q.size();
    data_in    = d;
    config_reg = c;
    set_start(fast, 1'b1);
    @(negedge clk);
    set_start(fast, 1'b0);
    check({tag, " busy_rise"}, fast ? busy_f : busy_s, 1'b1);
    for (int t = 0; t < n * p; t++) begin
      if ((t % p == 0) || (t % p == p - 1)) begin
        check($sformatf("%s bit%0d@%0d", tag, t / p, t), fast ? tx_f : tx_s, q[t / p]);
        check($sformatf("%s no_done@%0d", tag, t), fast ? done_f : done_s, 1'b0);
      end
      if (t == 1) begin
        data_in    = 8'($urandom);
        config_reg = 6'($urandom);
      end
      if (disturb) set_start(fast, logic'(t == 3 * p + 5));
      @(negedge clk);
    end
    set_start(fast, 1'b0);
    check({tag, " done"}, fast ? done_f : done_s, 1'b1);
    check({tag, " busy_fall"}, fast ? busy_f : busy_s, 1'b0);
    check({tag, " tx_idle"}, fast ? tx_f : tx_s, 1'b1);
  endtask

  task automatic idle_check(input bit fast, input string tag);
    @(negedge clk);
    check({tag, " done_pulse_end"}, fast ? done_f : done_s, 1'b0);
    check({tag, " idle_busy"}, fast ? busy_f : busy_s, 1'b0);
    check({tag, " idle_tx"}, fast ? tx_f : tx_s, 1'b1);
  endtask

  // Asynchronous reset between clock edges; outputs must react without a clock
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, " rst_tx_s"}, tx_s, 1'b1);
    check({tag, " rst_busy_s"}, busy_s, 1'b0);
    check({tag, " rst_done_s"}, done_s, 1'b0);
    check({tag, " rst_tx_f"}, tx_f, 1'b1);
    check({tag, " rst_busy_f"}, busy_f, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Default-rate start bit length for one baud setting, then abort with reset
  task automatic start_probe(input logic [1:0] bd);
    int p;
    p = 16 * div_of(1'b0, bd);
    data_in    = 8'h01;
    config_reg = {4'b1000, bd};
    start_s    = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int t = 0; t < p; t++) begin
      if (t == 0 || t == p - 1) check($sformatf("probe%0d start@%0d", bd, t), tx_s, 1'b0);
      @(negedge clk);
    end
    check($sformatf("probe%0d d0", bd), tx_s, 1'b1);
    check($sformatf("probe%0d busy", bd), busy_s, 1'b1);
    async_reset($sformatf("probe%0d", bd));
  endtask

  initial begin
    reset      = 1'b1;
    start_s    = 1'b0;
    start_f    = 1'b0;
    data_in    = '0;
    config_reg = '0;
    repeat (3) @(negedge clk);
    check("por tx_s", tx_s, 1'b1);
    check("por busy_s", busy_s, 1'b0);
    check("por done_s", done_s, 1'b0);
    check("por tx_f", tx_f, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // 8-bit even parity, 1 stop, fastest default rate: 11 periods of 1600 clk
    run_frame(1'b0, 8'hA5, 6'b101011, 1'b0, "even8");
    idle_check(1'b0, "even8");

    start_probe(2'b00);
    start_probe(2'b01);
    start_probe(2'b10);

    // 7-bit odd parity, two stop bits; data bit 7 must be dropped
    run_frame(1'b1, 8'hD5, 6'b010111, 1'b0, "odd7");
    idle_check(1'b1, "odd7");

    // Mid-frame tx_start pulse and config/data churn must not disturb the frame
    run_frame(1'b1, 8'h3C, 6'b000011, 1'b1, "ignore");
    idle_check(1'b1, "ignore");
    repeat (40) @(negedge clk);
    check("ignore no_requeue_busy", busy_f, 1'b0);
    check("ignore no_requeue_tx", tx_f, 1'b1);

    // Abort during data bit 3, then a full frame must follow cleanly
    data_in    = 8'hF7;
    config_reg = 6'b100000;
    start_f    = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    repeat (4 * 96 + 48) @(negedge clk);
    check("abort d3", tx_f, 1'b0);
    check("abort busy", busy_f, 1'b1);
    async_reset("abort");
    run_frame(1'b1, 8'h96, 6'b101001, 1'b0, "post_abort");
    idle_check(1'b1, "post_abort");

    // Back-to-back accept in the tx_done cycle, then randomized frames
    run_frame(1'b1, 8'h55, 6'b101010, 1'b0, "b2b_55");
    run_frame(1'b1, 8'hAA, 6'b101010, 1'b0, "b2b_aa");
    idle_check(1'b1, "b2b");
    for (int i = 0; i < 28; i++) begin
      run_frame(1'b1, 8'($urandom), 6'($urandom), bit'($urandom_range(0, 1)),
                $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle_check(1'b1, $sformatf("rnd%0d", i));
    end
    idle_check(1'b1, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
